// File: rtl/frame_mem_pkg.sv
// Constants and types shared by the frame-memory write (pack) and read (fetch) paths.
// The address holds a bank bit in the MSB and a word index below it.
package frame_mem_pkg;

  localparam int WORDS_PER_FRAME = 19200;
  localparam int BYTES_PER_WORD  = 16;
  localparam int MEM_DATA_W      = 128;
  localparam int ADDR_W          = 16;
  localparam int BANK_BIT        = ADDR_W - 1;
  localparam int INDEX_W         = BANK_BIT;
  localparam int CNT_W           = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {IDLE, PACK, DONE} frame_state_e;

  function automatic logic [ADDR_W-1:0] frame_addr(input logic bank,
                                                   input logic [INDEX_W-1:0] index);
    return {bank, index};
  endfunction

endpackage

// File: rtl/input_pack_mem_if.sv
// Byte-source and memory-write-port signals of the frame packer.
// The slave modport is the packer; the master modport is whatever drives it.
interface input_pack_mem_if;
  import frame_mem_pkg::*;

  logic                  start;
  logic                  input_base_offset;
  logic [7:0]            DataIn;
  logic                  DataValid;
  logic [MEM_DATA_W-1:0] WriteBus;
  logic [ADDR_W-1:0]     WriteAddress;
  logic                  WriteEnable;
  logic                  busy;
  logic                  done;

  modport master (
    output start, input_base_offset, DataIn, DataValid,
    input  WriteBus, WriteAddress, WriteEnable, busy, done
  );

  modport slave (
    input  start, input_base_offset, DataIn, DataValid,
    output WriteBus, WriteAddress, WriteEnable, busy, done
  );

endinterface

// File: rtl/byte_packer_128.sv
// Shifts bytes in from the LSB end and counts them; word_complete flags the 16th byte,
// with word already including that byte so the caller can register it on the same edge.
module byte_packer_128
  import frame_mem_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_dat,
  output logic [MEM_DATA_W-1:0] word,
  output logic                  word_complete
);

  logic [MEM_DATA_W-1:0] shreg;
  logic [CNT_W-1:0]      count;

  assign word          = {shreg[MEM_DATA_W-9:0], byte_dat};
  assign word_complete = byte_vld && !clear && (count == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      count <= '0;
    end else if (clear) begin
      shreg <= '0;
      count <= '0;
    end else if (byte_vld) begin
      shreg <= word;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/input_pack_mem.sv
// Packs a byte stream into 128-bit words and writes them to one of two frame banks,
// raising done with the final word's strobe and holding it until start drops.
module input_pack_mem
  import frame_mem_pkg::*;
#(
  parameter int FRAME_WORDS = frame_mem_pkg::WORDS_PER_FRAME
) (
  input logic              clock,
  input logic              reset,
  input_pack_mem_if.slave  bus
);

  frame_state_e          state, state_nxt;
  logic                  bank;
  logic [INDEX_W-1:0]    index;
  logic                  accept;
  logic                  clear;
  logic                  last_word;
  logic                  word_complete;
  logic [MEM_DATA_W-1:0] word;

  logic [MEM_DATA_W-1:0] write_bus_q;
  logic [ADDR_W-1:0]     write_addr_q;
  logic                  write_en_q;

  // A byte is only taken while actively packing; an abort cycle discards it.
  assign accept    = (state == PACK) && bus.start && bus.DataValid;
  assign clear     = (state != PACK);
  assign last_word = (index == INDEX_W'(FRAME_WORDS - 1));

  byte_packer_128 u_packer (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .byte_vld      (accept),
    .byte_dat      (bus.DataIn),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = PACK;
      PACK: begin
        if (!bus.start)                      state_nxt = IDLE;
        else if (word_complete && last_word) state_nxt = DONE;
      end
      DONE: if (!bus.start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index        <= '0;
      bank         <= 1'b0;
      write_bus_q  <= '0;
      write_addr_q <= '0;
      write_en_q   <= 1'b0;
    end else begin
      write_en_q <= word_complete;
      if (state == IDLE) begin
        index <= '0;
        bank  <= bus.input_base_offset;
      end else if (word_complete) begin
        write_bus_q  <= word;
        write_addr_q <= frame_addr(bank, index);
        index        <= index + 1'b1;
      end
    end
  end

  assign bus.WriteBus     = write_bus_q;
  assign bus.WriteAddress = write_addr_q;
  assign bus.WriteEnable  = write_en_q;
  assign bus.busy         = (state == PACK);
  assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_input_pack_mem.sv
// Bench for input_pack_mem with a 4-word frame: table vectors plus corner-case sequences,
// checked against a scoreboard of expected memory writes.
module tb_input_pack_mem;
  import frame_mem_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  input_pack_mem_if bus();

  input_pack_mem #(.FRAME_WORDS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
    logic         done;
  } exp_t;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
    logic         done;
    int           cyc;
  } obs_t;

  typedef struct {
    logic         bank;
    logic [7:0]   base;
    int           gap;
    int           nwords;
    logic [15:0]  addr0;
    logic [127:0] data0;
  } vec_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  vec_t vecs[3];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.WriteEnable === 1'b1)
      obs_q.push_back('{bus.WriteAddress, bus.WriteBus, bus.done, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, expv);
  endtask

  function automatic logic [127:0] seq_word(input logic [7:0] base);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w = {w[119:0], 8'(base + 8'(i))};
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.DataIn    = b;
    bus.DataValid = 1'b1;
    tick();
    bus.DataValid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_word(input logic [7:0] base, input int gap);
    for (int i = 0; i < 16; i++) send_byte(8'(base + 8'(i)), gap);
  endtask

  task automatic drain(input string name);
    exp_t e;
    obs_t o;
    while (exp_q.size() > 0) begin
      int k = 0;
      while (obs_q.size() == 0 && k < 64) begin
        tick();
        k++;
      end
      if (obs_q.size() == 0) begin
        n_total++;
        $display("FAIL %s_timeout: got no write, required write to %0h", name, exp_q[0].addr);
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({name, "_addr"}, o.addr, e.addr);
      chk({name, "_data"}, o.data, e.data);
      chk({name, "_done"}, o.done, e.done);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_bus"},  bus.WriteBus, 0);
    chk({name, "_addr"}, bus.WriteAddress, 0);
    chk({name, "_we"},   bus.WriteEnable, 0);
    chk({name, "_busy"}, bus.busy, 0);
    chk({name, "_done"}, bus.done, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h00, 1, 1, 16'h0000, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[1] = '{1'b1, 8'hA0, 2, 2, 16'h8000, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF};
    vecs[2] = '{1'b0, 8'h30, 3, 1, 16'h0000, 128'h303132333435363738393A3B3C3D3E3F};

    reset                 = 1'b1;
    bus.start             = 1'b0;
    bus.input_base_offset = 1'b0;
    bus.DataIn            = 8'h00;
    bus.DataValid         = 1'b0;
    #3;
    check_outputs_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Table-driven single/multi-word frames
    for (int v = 0; v < 3; v++) begin
      bus.input_base_offset = vecs[v].bank;
      bus.start = 1'b1;
      tick();
      chk($sformatf("vec%0d_busy", v), bus.busy, 1);
      for (int w = 0; w < vecs[v].nwords; w++) begin
        send_word(8'(vecs[v].base + 8'(16 * w)), vecs[v].gap);
        if (w == 0) exp_q.push_back('{vecs[v].addr0, vecs[v].data0, 1'b0});
        else exp_q.push_back('{16'(vecs[v].addr0 + 16'(w)),
                               seq_word(8'(vecs[v].base + 8'(16 * w))), 1'b0});
      end
      drain($sformatf("vec%0d", v));
      bus.start = 1'b0;
      tick();
      chk($sformatf("vec%0d_idle_busy", v), bus.busy, 0);
      chk($sformatf("vec%0d_idle_we", v), bus.WriteEnable, 0);
    end

    // Full frame at full rate
    bus.input_base_offset = 1'b0;
    bus.start = 1'b1;
    tick();
    for (int w = 0; w < 4; w++) begin
      send_word(8'(16 * w), 1);
      exp_q.push_back('{16'(w), seq_word(8'(16 * w)), (w == 3)});
    end
    for (int k = 0; k < 8 && obs_q.size() < 4; k++) tick();
    if (obs_q.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        chk($sformatf("frame_spacing%0d", i), obs_q[i].cyc - obs_q[i-1].cyc, 16);
    end else begin
      n_total++;
      $display("FAIL frame_strobes: got %0d writes required 4", obs_q.size());
    end
    drain("frame");
    chk("frame_done_held", bus.done, 1);
    chk("frame_busy_low", bus.busy, 0);
    send_word(8'hC0, 1);
    repeat (3) tick();
    chk("frame_extra_no_write", obs_q.size(), 0);
    chk("frame_done_still", bus.done, 1);
    bus.start = 1'b0;
    tick();
    chk("frame_done_clear", bus.done, 0);

    // Abort after 10 bytes, then a clean word
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + 8'(i)), 1);
    bus.start = 1'b0;
    repeat (20) tick();
    chk("abort_no_write", obs_q.size(), 0);
    chk("abort_busy", bus.busy, 0);
    bus.start = 1'b1;
    tick();
    send_word(8'h50, 1);
    exp_q.push_back('{16'h0000, seq_word(8'h50), 1'b0});
    drain("abort_restart");
    bus.start = 1'b0;
    tick();

    // Asynchronous reset after 7 bytes
    bus.input_base_offset = 1'b1;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) send_byte(8'(8'h60 + 8'(i)), 1);
    chk("areset_busy_before", bus.busy, 1);
    #2;
    reset = 1'b1;
    bus.start = 1'b0;
    #1;
    check_outputs_zero("areset");
    reset = 1'b0;
    bus.input_base_offset = 1'b0;
    repeat (3) tick();
    chk("areset_no_write", obs_q.size(), 0);
    bus.start = 1'b1;
    tick();
    send_word(8'h80, 1);
    exp_q.push_back('{16'h0000, seq_word(8'h80), 1'b0});
    drain("areset_new");
    bus.start = 1'b0;
    tick();

    // Byte presented on the start-rise cycle is not packed
    bus.start     = 1'b1;
    bus.DataIn    = 8'hEE;
    bus.DataValid = 1'b1;
    tick();
    send_word(8'h90, 1);
    exp_q.push_back('{16'h0000, seq_word(8'h90), 1'b0});
    drain("start_edge");
    bus.start = 1'b0;
    repeat (4) tick();
    chk("no_stray_writes", obs_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
